ddr3_rd_lane_ctrl: RTL and testbench
====================================

DDR3_RD_LANE_CTRL -- requirements
Module: ddr3_rd_lane_ctrl

Interface
REQ-001 Parameter: RD_LATENCY, 6, fabric cycles from command accept to DDR_READ assertion (legal 2..15).
REQ-002 Parameter: BURST_CYCLES, 2, fabric cycles per read burst; also the number of data beats per command (legal 1..4).
REQ-003 Parameter: TIMEOUT, 32, idle cycles tolerated while reads are outstanding (legal 8..255).
REQ-004 Port: FAB_CLK  input  1  sole clock, rising-edge.
REQ-005 Port: ARST_N  input  1  asynchronous reset, active-low. One clock; reset is asynchronous and active-low.
REQ-006 Port: RD_CMD_VALID  input  1  read command request.
REQ-007 Port: RD_CMD_TAG  input  2  tag accompanying the command.
REQ-008 Port: RD_CMD_READY  output  1  command accepted when VALID and READY are both high.
REQ-009 Port: DDR_READ  output  1  read window to the lane controller.
REQ-010 Port: RX_DATA_VALID  input  1  one captured beat available in the lane FIFO.
REQ-011 Port: RX_BURST_DETECT  input  1  DQS preamble seen; informational, counted only.
REQ-012 Port: FIFO_RD_PTR  output  3  lane FIFO read pointer.
REQ-013 Port: RD_DATA_VALID  output  1  beat delivered to the fabric.
REQ-014 Port: RD_DATA_TAG  output  2  tag of the delivered beat.
REQ-015 Port: RD_DATA_LAST  output  1  final beat of a command.
REQ-016 Port: OUTSTANDING  output  3  commands accepted and not yet completed (0..4).
REQ-017 Port: BURST_CNT  output  8  saturating count of RX_BURST_DETECT rising edges.
REQ-018 Port: RD_ERR  output  1  sticky protocol error flag.

Function
REQ-019 RD_CMD_READY = (OUTSTANDING < 4) and spacing counter == 0; after each accept, the spacing counter loads BURST_CYCLES-1, so accepts are at least BURST_CYCLES cycles apart.
REQ-020 On accept, push the tag into a 4-deep tag FIFO and inject a pulse into a RD_LATENCY-stage delay line.
REQ-021 When a pulse exits the delay line, load the window counter with BURST_CYCLES; DDR_READ is registered high while the window counter is nonzero.
REQ-022 Result: DDR_READ rises exactly RD_LATENCY cycles after the accept edge and stays high for BURST_CYCLES cycles. Windows from minimum-spaced commands abut with no gap.
REQ-023 Beat FSM states: IDLE, WAIT, BURST.
  - IDLE -> WAIT on accept.
  - WAIT -> BURST on the first RX_DATA_VALID.
  - BURST -> WAIT, or IDLE if none remain, after beat BURST_CYCLES.
REQ-024 Each cycle with RX_DATA_VALID high and OUTSTANDING > 0:
  - the next cycle, RD_DATA_VALID=1 and RD_DATA_TAG = tag FIFO head;
  - FIFO_RD_PTR increments, wrapping 7 -> 0;
  - the beat counter increments.
REQ-025 On beat number BURST_CYCLES: RD_DATA_LAST=1 with that beat, pop the tag FIFO, clear the beat counter, and decrement OUTSTANDING.
REQ-026 An accept and a completion in the same cycle leave OUTSTANDING unchanged; the tag FIFO pushes and pops together.
REQ-027 RX_DATA_VALID with OUTSTANDING == 0:
  - set RD_ERR;
  - no RD_DATA_VALID;
  - FIFO_RD_PTR is not advanced.
REQ-028 RD_ERR is sticky until reset and does not block further operation.
REQ-029 BURST_CNT increments on each 0->1 transition of RX_BURST_DETECT and saturates at 255.

Reset
REQ-030 ARST_N low asynchronously clears all of the following:
  - outputs: DDR_READ, RD_DATA_VALID, RD_DATA_LAST, RD_DATA_TAG, FIFO_RD_PTR, OUTSTANDING, BURST_CNT, RD_ERR, RD_CMD_READY;
  - internal state: delay line, window, spacing and beat counters, tag FIFO, timeout counter; FSM returns to IDLE.
REQ-031 Reset mid-burst discards in-flight commands with no completion beat. Deassertion is synchronised internally; RD_CMD_READY rises on the second FAB_CLK edge after ARST_N rises.

Configuration
REQ-032 Macro DDR3_RD_TIMEOUT_EN, when defined, adds the read watchdog:
  - a counter increments while OUTSTANDING > 0 and no RX_DATA_VALID occurs, and clears on any beat;
  - on reaching TIMEOUT it sets RD_ERR, flushes the tag FIFO, the delay line and the window counter, forces OUTSTANDING to 0 and the FSM to IDLE, and leaves FIFO_RD_PTR unchanged.
REQ-033 Without DDR3_RD_TIMEOUT_EN, no watchdog logic exists, and missing data leaves OUTSTANDING nonzero indefinitely.

Verification
REQ-034 Single read, tag 2, defaults: accept at cycle 0.
  - DDR_READ high in cycles 6-7.
  - RX_DATA_VALID in cycles 10-11 -> RD_DATA_VALID in cycles 11-12, tag 2, LAST in cycle 12.
  - FIFO_RD_PTR 0 -> 2; OUTSTANDING 1 -> 0.
REQ-035 Five back-to-back VALIDs:
  - accepts at cycles 0, 2, 4, 6;
  - READY stays low once OUTSTANDING = 4;
  - DDR_READ is continuously high in cycles 6-13;
  - the returned tags come back in order.
REQ-036 Wrap: five completed reads -> FIFO_RD_PTR sequence 0..7,0,1, ending at 2.
REQ-037 Stray RX_DATA_VALID when idle -> RD_ERR=1, RD_DATA_VALID stays 0, FIFO_RD_PTR unchanged.
REQ-038 With DDR3_RD_TIMEOUT_EN: accept a read and never return data.
  - RD_ERR rises 32 cycles after the last activity, and OUTSTANDING goes to 0.
  - A new accept is possible the next cycle.
REQ-039 ARST_N pulse during a burst -> all outputs 0 immediately and no LAST beat is emitted.

Source files
------------

// File: rtl/ddr3_rd_lane_ctrl.sv
// ddr3_rd_lane_ctrl: DDR3 read lane sequencer: command spacing, latency-aligned read window, tagged beat delivery.
// Optional read watchdog enabled by defining DDR3_RD_TIMEOUT_EN.
module ddr3_rd_lane_ctrl #(
   parameter int RD_LATENCY   = 6,
   parameter int BURST_CYCLES = 2,
   parameter int TIMEOUT      = 32
) (
   input  logic       FAB_CLK,
   input  logic       ARST_N,
   input  logic       RD_CMD_VALID,
   input  logic [1:0] RD_CMD_TAG,
   output logic       RD_CMD_READY,
   output logic       DDR_READ,
   input  logic       RX_DATA_VALID,
   input  logic       RX_BURST_DETECT,
   output logic [2:0] FIFO_RD_PTR,
   output logic       RD_DATA_VALID,
   output logic [1:0] RD_DATA_TAG,
   output logic       RD_DATA_LAST,
   output logic [2:0] OUTSTANDING,
   output logic [7:0] BURST_CNT,
   output logic       RD_ERR
);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;
   state_t                state_q;
   logic [1:0]            sync_q;
   logic [RD_LATENCY-1:0] dl_q, dl_d;
   logic [2:0]            win_q, win_d;
   logic [1:0]            spc_q, spc_d;
   logic [1:0]            beat_q, beat_d;
   logic [3:0][1:0]       tag_q, tag_d;
   logic [1:0]            wp_q, wp_d, rp_q, rp_d;
   logic [2:0]            out_q, out_d, ptr_q, ptr_d;
   logic                  dv_q, dv_d, last_q, last_d, err_q, err_d, det_q, ddr_q, ddr_d;
   logic [1:0]            dtag_q, dtag_d;
   logic [7:0]            bcnt_q, bcnt_d;
   logic                  rx, det, acc, beat, last, to_fire;
`ifdef DDR3_RD_TIMEOUT_EN
   logic [7:0]            to_q, to_d;
`endif
   always_comb begin
      rx = RX_DATA_VALID & sync_q[1];
      det = RX_BURST_DETECT & sync_q[1];
`ifdef DDR3_RD_TIMEOUT_EN
      to_fire = out_q != 3'd0 && !rx && to_q == 8'(TIMEOUT-1);
      to_d = (out_q == 3'd0 || rx || to_fire) ? 8'd0 : to_q + 8'd1;
`else
      to_fire = 1'b0;
`endif
      RD_CMD_READY = sync_q[1] && out_q < 3'd4 && spc_q == 2'd0 && !to_fire;
      acc = RD_CMD_VALID && RD_CMD_READY;
      beat = rx && out_q != 3'd0;
      last = beat && beat_q == 2'(BURST_CYCLES-1);
      dl_d = to_fire ? '0 : {dl_q[RD_LATENCY-2:0], acc};
      // a pulse leaving the delay line opens the window; spacing guarantees no overlap
      win_d = to_fire ? 3'd0 : dl_q[RD_LATENCY-1] ? 3'(BURST_CYCLES) : (win_q != 3'd0 ? win_q - 3'd1 : 3'd0);
      ddr_d = win_d != 3'd0;
      spc_d = acc ? 2'(BURST_CYCLES-1) : (spc_q != 2'd0 ? spc_q - 2'd1 : 2'd0);
      beat_d = (last || to_fire) ? 2'd0 : beat ? beat_q + 2'd1 : beat_q;
      tag_d = tag_q;
      if (acc) tag_d[wp_q] = RD_CMD_TAG;
      wp_d = to_fire ? 2'd0 : wp_q + {1'b0, acc};
      rp_d = to_fire ? 2'd0 : rp_q + {1'b0, last};
      out_d = to_fire ? 3'd0 : out_q + {2'b0, acc} - {2'b0, last};
      ptr_d = ptr_q + {2'b0, beat};
      dv_d = beat;
      last_d = last;
      dtag_d = beat ? tag_q[rp_q] : dtag_q;
      bcnt_d = bcnt_q + {7'b0, det && !det_q && bcnt_q != 8'hff};
      err_d = err_q || (rx && out_q == 3'd0) || to_fire;
   end
   always_ff @(posedge FAB_CLK or negedge ARST_N) begin
      if (!ARST_N) sync_q <= 2'b00;
      else         sync_q <= {sync_q[0], 1'b1};
   end
   always_ff @(posedge FAB_CLK or negedge ARST_N) begin
      if (!ARST_N) begin
         dl_q   <= '0;
         win_q  <= 3'd0;
         spc_q  <= 2'd0;
         beat_q <= 2'd0;
         tag_q  <= '0;
         wp_q   <= 2'd0;
         rp_q   <= 2'd0;
         out_q  <= 3'd0;
         ptr_q  <= 3'd0;
         dv_q   <= 1'b0;
         last_q <= 1'b0;
         dtag_q <= 2'd0;
         bcnt_q <= 8'd0;
         err_q  <= 1'b0;
         det_q  <= 1'b0;
         ddr_q  <= 1'b0;
      end else begin
         dl_q   <= dl_d;
         win_q  <= win_d;
         spc_q  <= spc_d;
         beat_q <= beat_d;
         tag_q  <= tag_d;
         wp_q   <= wp_d;
         rp_q   <= rp_d;
         out_q  <= out_d;
         ptr_q  <= ptr_d;
         dv_q   <= dv_d;
         last_q <= last_d;
         dtag_q <= dtag_d;
         bcnt_q <= bcnt_d;
         err_q  <= err_d;
         det_q  <= det;
         ddr_q  <= ddr_d;
      end
   end
`ifdef DDR3_RD_TIMEOUT_EN
   always_ff @(posedge FAB_CLK or negedge ARST_N) begin
      if (!ARST_N) to_q <= 8'd0;
      else         to_q <= to_d;
   end
`endif
   always_ff @(posedge FAB_CLK or negedge ARST_N) begin
      if (!ARST_N) state_q <= S_IDLE;
      else if (to_fire) state_q <= S_IDLE;
      else begin
         case (state_q)
            S_IDLE:  if (acc) state_q <= S_WAIT;
            S_WAIT:  if (beat) state_q <= last ? (out_d != 3'd0 ? S_WAIT : S_IDLE) : S_BURST;
            S_BURST: if (last) state_q <= out_d != 3'd0 ? S_WAIT : S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end
   assign DDR_READ      = ddr_q;
   assign FIFO_RD_PTR   = ptr_q;
   assign RD_DATA_VALID = dv_q;
   assign RD_DATA_TAG   = dtag_q;
   assign RD_DATA_LAST  = last_q;
   assign OUTSTANDING   = out_q;
   assign BURST_CNT     = bcnt_q;
   assign RD_ERR        = err_q;
endmodule

// File: tb/tb_ddr3_rd_lane_ctrl.sv
// tb_ddr3_rd_lane_ctrl: vector table, directed corner sequences and a randomized run against a transaction-level model.
module tb_ddr3_rd_lane_ctrl;
   localparam int L = 6, B = 2, TO = 32;
`ifdef DDR3_RD_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   logic FAB_CLK = 1'b0, ARST_N = 1'b0, RD_CMD_VALID = 1'b0, RX_DATA_VALID = 1'b0, RX_BURST_DETECT = 1'b0;
   logic [1:0] RD_CMD_TAG = 2'd0;
   logic RD_CMD_READY, DDR_READ, RD_DATA_VALID, RD_DATA_LAST, RD_ERR;
   logic [2:0] FIFO_RD_PTR, OUTSTANDING;
   logic [1:0] RD_DATA_TAG;
   logic [7:0] BURST_CNT;
   int checks = 0, fails = 0;

   ddr3_rd_lane_ctrl #(.RD_LATENCY(L), .BURST_CYCLES(B), .TIMEOUT(TO)) dut (
      .FAB_CLK(FAB_CLK), .ARST_N(ARST_N), .RD_CMD_VALID(RD_CMD_VALID), .RD_CMD_TAG(RD_CMD_TAG),
      .RD_CMD_READY(RD_CMD_READY), .DDR_READ(DDR_READ), .RX_DATA_VALID(RX_DATA_VALID),
      .RX_BURST_DETECT(RX_BURST_DETECT), .FIFO_RD_PTR(FIFO_RD_PTR), .RD_DATA_VALID(RD_DATA_VALID),
      .RD_DATA_TAG(RD_DATA_TAG), .RD_DATA_LAST(RD_DATA_LAST), .OUTSTANDING(OUTSTANDING),
      .BURST_CNT(BURST_CNT), .RD_ERR(RD_ERR));

   always #5 FAB_CLK = ~FAB_CLK;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "time limit");
   end

   typedef struct {
      logic vld; logic [1:0] tag; logic rx;
      logic ddr, dv, last; logic [1:0] dtag; int out, ptr;
   } vec_t;
   vec_t tbl[14];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge FAB_CLK);
      #1;
   endtask

   function automatic int all_outs();
      return int'({DDR_READ, RD_DATA_VALID, RD_DATA_TAG, RD_DATA_LAST, OUTSTANDING,
                   FIFO_RD_PTR, BURST_CNT, RD_ERR, RD_CMD_READY});
   endfunction

   task automatic do_reset();
      RD_CMD_VALID = 0; RD_CMD_TAG = 0; RX_DATA_VALID = 0; RX_BURST_DETECT = 0;
      ARST_N = 0;
      #12;
      chk("reset_outputs_zero", all_outs(), 0);
      @(negedge FAB_CLK);
      ARST_N = 1;
      tick();
      tick();
   endtask

   // transaction-level reference state
   int acc_t[$];
   logic [1:0] tq[$];
   int m_out, m_ptr, m_beats, m_bcnt, m_idle, m_last_acc;
   bit m_err, m_prev_det;

   initial begin
      // reset release synchronisation
      ARST_N = 0;
      #12;
      chk("rst_all_zero", all_outs(), 0);
      @(negedge FAB_CLK);
      ARST_N = 1;
      tick();
      chk("rst_ready_edge1", RD_CMD_READY, 0);
      tick();
      chk("rst_ready_edge2", RD_CMD_READY, 1);

      // single read, tag 2
      for (int i = 0; i < 14; i++) tbl[i] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1, 0};
      tbl[0].vld = 1; tbl[0].tag = 2;
      tbl[6].ddr = 1; tbl[7].ddr = 1;
      tbl[11].rx = 1; tbl[11].dv = 1; tbl[11].dtag = 2; tbl[11].ptr = 1;
      tbl[12].rx = 1; tbl[12].dv = 1; tbl[12].dtag = 2; tbl[12].last = 1; tbl[12].out = 0; tbl[12].ptr = 2;
      tbl[13].out = 0; tbl[13].ptr = 2;
      for (int i = 0; i < 14; i++) begin
         RD_CMD_VALID = tbl[i].vld; RD_CMD_TAG = tbl[i].tag; RX_DATA_VALID = tbl[i].rx;
         tick();
         chk("tbl_ddr_read", DDR_READ, tbl[i].ddr);
         chk("tbl_data_valid", RD_DATA_VALID, tbl[i].dv);
         chk("tbl_data_last", RD_DATA_LAST, tbl[i].last);
         chk("tbl_outstanding", OUTSTANDING, tbl[i].out);
         chk("tbl_fifo_ptr", FIFO_RD_PTR, tbl[i].ptr);
         if (tbl[i].dv) chk("tbl_data_tag", RD_DATA_TAG, tbl[i].dtag);
      end
      RD_CMD_VALID = 0; RX_DATA_VALID = 0;

      // back-to-back commands until the tag FIFO is full
      do_reset();
      begin
         int nacc = 0;
         for (int n = 0; n < 16; n++) begin
            RD_CMD_VALID = 1; RD_CMD_TAG = 2'(nacc);
            #1;
            chk("b2b_ready", RD_CMD_READY, int'(n == 0 || n == 2 || n == 4 || n == 6));
            if (RD_CMD_READY) nacc++;
            tick();
            chk("b2b_ddr_read", DDR_READ, int'(n >= 6 && n <= 13));
         end
         chk("b2b_outstanding_full", OUTSTANDING, 4);
         RD_CMD_VALID = 0; RX_DATA_VALID = 1;
         for (int k = 0; k < 8; k++) begin
            tick();
            chk("b2b_tag_order", RD_DATA_TAG, k / 2);
            chk("b2b_last", RD_DATA_LAST, k % 2);
         end
         RX_DATA_VALID = 0;
         tick();
         chk("b2b_outstanding_end", OUTSTANDING, 0);
      end

      // FIFO_RD_PTR wrap over five reads, then a stray beat
      do_reset();
      chk("wrap_ptr_start", FIFO_RD_PTR, 0);
      for (int r = 0; r < 5; r++) begin
         RD_CMD_VALID = 1; RD_CMD_TAG = 2'(r);
         tick();
         RD_CMD_VALID = 0;
         repeat (3) tick();
         RX_DATA_VALID = 1;
         for (int b = 0; b < 2; b++) begin
            tick();
            chk("wrap_ptr", FIFO_RD_PTR, (2 * r + b + 1) % 8);
         end
         RX_DATA_VALID = 0;
         tick();
      end
      chk("stray_err_before", RD_ERR, 0);
      RX_DATA_VALID = 1;
      tick();
      RX_DATA_VALID = 0;
      chk("stray_err_set", RD_ERR, 1);
      chk("stray_no_valid", RD_DATA_VALID, 0);
      chk("stray_ptr_hold", FIFO_RD_PTR, 2);
      tick();
      chk("stray_err_sticky", RD_ERR, 1);
      RD_CMD_VALID = 1; RD_CMD_TAG = 3;
      tick();
      RD_CMD_VALID = 0;
      chk("err_no_block", OUTSTANDING, 1);

      // reset asserted in the middle of a burst
      do_reset();
      RD_CMD_VALID = 1; RD_CMD_TAG = 1;
      tick();
      RD_CMD_VALID = 0;
      repeat (9) tick();
      RX_DATA_VALID = 1;
      tick();
      chk("mid_first_beat", RD_DATA_VALID, 1);
      chk("mid_first_not_last", RD_DATA_LAST, 0);
      #2;
      ARST_N = 0;
      #1;
      chk("mid_async_clear", all_outs(), 0);
      tick();
      chk("mid_no_last", RD_DATA_LAST, 0);
      chk("mid_no_valid", RD_DATA_VALID, 0);
      RX_DATA_VALID = 0;
      @(negedge FAB_CLK);
      ARST_N = 1;
      tick();
      tick();
      chk("mid_outstanding_cleared", OUTSTANDING, 0);
      chk("mid_ready_back", RD_CMD_READY, 1);

`ifdef DDR3_RD_TIMEOUT_EN
      // read that never returns data
      do_reset();
      RD_CMD_VALID = 1; RD_CMD_TAG = 0;
      tick();
      RD_CMD_VALID = 0;
      for (int i = 1; i <= TO; i++) begin
         #1;
         chk("to_ready", RD_CMD_READY, int'(i != TO));
         tick();
         chk("to_err", RD_ERR, int'(i == TO));
         chk("to_outstanding", OUTSTANDING, i == TO ? 0 : 1);
      end
      chk("to_ready_after", RD_CMD_READY, 1);
      RD_CMD_VALID = 1;
      tick();
      RD_CMD_VALID = 0;
      chk("to_new_accept", OUTSTANDING, 1);
`else
      // without the watchdog a read that never returns stays outstanding
      do_reset();
      RD_CMD_VALID = 1; RD_CMD_TAG = 0;
      tick();
      RD_CMD_VALID = 0;
      repeat (TO + 20) tick();
      chk("no_to_outstanding", OUTSTANDING, 1);
      chk("no_to_err", RD_ERR, 0);
`endif

      // randomized traffic against the reference model
      do_reset();
      acc_t.delete(); tq.delete();
      m_out = 0; m_ptr = 0; m_beats = 0; m_bcnt = 0; m_idle = 0; m_last_acc = -100;
      m_err = 0; m_prev_det = 0;
      for (int n = 0; n < 3000; n++) begin
         bit v, rx, det, fire, rdy, acc, beat, done, exp_ddr, exp_last;
         logic [1:0] tg, exp_tag;
         v = 1'($urandom_range(0, 1));
         tg = 2'($urandom_range(0, 3));
         rx = $urandom_range(0, 9) < 4;
         det = 1'($urandom_range(0, 1));
         RD_CMD_VALID = v; RD_CMD_TAG = tg; RX_DATA_VALID = rx; RX_BURST_DETECT = det;
         fire = TO_EN && m_out > 0 && !rx && m_idle == TO - 1;
         rdy = m_out < 4 && (n - m_last_acc) >= B && !fire;
         #1;
         chk("rnd_ready", RD_CMD_READY, rdy);
         acc = v && rdy;
         beat = rx && m_out > 0;
         done = 0; exp_last = 0; exp_tag = 0;
         if (rx && m_out == 0) m_err = 1;
         if (acc) begin
            tq.push_back(tg);
            acc_t.push_back(n);
            m_last_acc = n;
         end
         if (beat) begin
            exp_tag = tq[0];
            m_beats++;
            m_ptr = (m_ptr + 1) % 8;
            if (m_beats == B) begin
               exp_last = 1;
               done = 1;
               m_beats = 0;
               void'(tq.pop_front());
            end
         end
         m_idle = (m_out == 0 || rx || fire) ? 0 : m_idle + 1;
         m_out = m_out + int'(acc) - int'(done);
         if (fire) begin
            m_err = 1;
            m_out = 0;
            m_beats = 0;
            tq.delete();
            acc_t.delete();
         end
         if (det && !m_prev_det && m_bcnt < 255) m_bcnt++;
         m_prev_det = det;
         exp_ddr = 0;
         foreach (acc_t[i]) if (n >= acc_t[i] + L && n < acc_t[i] + L + B) exp_ddr = 1;
         while (acc_t.size() > 0 && acc_t[0] + L + B <= n) void'(acc_t.pop_front());
         tick();
         chk("rnd_ddr_read", DDR_READ, exp_ddr);
         chk("rnd_data_valid", RD_DATA_VALID, beat);
         if (beat) chk("rnd_data_tag", RD_DATA_TAG, exp_tag);
         chk("rnd_data_last", RD_DATA_LAST, exp_last);
         chk("rnd_outstanding", OUTSTANDING, m_out);
         chk("rnd_fifo_ptr", FIFO_RD_PTR, m_ptr);
         chk("rnd_burst_cnt", BURST_CNT, m_bcnt);
         chk("rnd_err", RD_ERR, m_err);
      end
      RD_CMD_VALID = 0; RX_DATA_VALID = 0; RX_BURST_DETECT = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
